aw_w_order_queue: RTL and testbench

Write-order tracking queue that sits directly downstream of the AW channel controller in the AXI interconnect write path. Each completed AW handshake pushes one entry: granted master ID, decoded target slave and burst length. The head entry steers the W channel. The block counts W beats against the stored length, generates the slave-side WLAST, and pops the entry on the last beat. `Queue_Is_Full` is returned to the AW controller so no further AW grant is issued while the queue cannot take it.

---
 rtl/aw_w_order_queue.sv | 99 +++++++++
 tb/tb_aw_w_order_queue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aw_w_order_queue.sv
// AW-to-W write-order queue: holds {master, slave, len} per accepted AW,
// steers W from the head entry, counts beats, makes WLAST, pops on last beat.
// Ports:
//   ACLK, ARESET          clock, async active-high reset
//   AW_Push, AW_Master_ID, AW_Slave_Sel, AW_Len   entry push side
//   Queue_Is_Full, Queue_Is_Empty, Queue_Count    occupancy status
//   W_Route_Valid, W_Master_Sel, W_Slave_Sel      head routing
//   W_Beat, W_Last_In, W_Last_Out                 beat tracking / WLAST
//   Protocol_Err          sticky error flag
module aw_w_order_queue #(
  parameter int Masters_Num   = 2,
  parameter int Num_Of_Slaves = 2,
  parameter int AXI4_Aw_len   = 8,
  parameter int Queue_Depth   = 4
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             AW_Push,
  input  logic [$clog2(Masters_Num)-1:0]   AW_Master_ID,
  input  logic [$clog2(Num_Of_Slaves)-1:0] AW_Slave_Sel,
  input  logic [AXI4_Aw_len-1:0]           AW_Len,
  output logic                             Queue_Is_Full,
  output logic                             Queue_Is_Empty,
  output logic [$clog2(Queue_Depth):0]     Queue_Count,
  output logic                             W_Route_Valid,
  output logic [$clog2(Masters_Num)-1:0]   W_Master_Sel,
  output logic [$clog2(Num_Of_Slaves)-1:0] W_Slave_Sel,
  input  logic                             W_Beat,
  input  logic                             W_Last_In,
  output logic                             W_Last_Out,
  output logic                             Protocol_Err
);

  localparam int IW = $clog2(Masters_Num);
  localparam int SW = $clog2(Num_Of_Slaves);
  localparam int AW = $clog2(Queue_Depth);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [IW-1:0]          id;
    logic [SW-1:0]          sl;
    logic [AXI4_Aw_len-1:0] len;
  } entry_t;

  entry_t                 mem [Queue_Depth];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [AXI4_Aw_len-1:0] beat_cnt;
  entry_t                 head;
  logic                   pop;
  logic                   push_ok;
  logic                   err_ev;

  assign head = mem[rd_ptr[AW-1:0]];

  assign Queue_Is_Empty = (wr_ptr == rd_ptr);
  assign Queue_Is_Full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                          (wr_ptr[AW] != rd_ptr[AW]);
  assign Queue_Count    = wr_ptr - rd_ptr;

  assign W_Route_Valid = !Queue_Is_Empty;
  // Gated so routing reads as zero when no entry is live (storage is not reset)
  assign W_Master_Sel  = W_Route_Valid ? head.id : '0;
  assign W_Slave_Sel   = W_Route_Valid ? head.sl : '0;
  assign W_Last_Out    = W_Route_Valid && (beat_cnt == head.len);

  assign pop     = W_Beat && W_Last_Out;
  // A pop frees the head slot this edge, so a full queue can still accept
  assign push_ok = AW_Push && (!Queue_Is_Full || pop);

  assign err_ev = (AW_Push && !push_ok) ||
                  (W_Beat && !W_Route_Valid) ||
                  (W_Beat && W_Route_Valid && (W_Last_In != W_Last_Out));

  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= '{id: AW_Master_ID, sl: AW_Slave_Sel, len: AW_Len};
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      beat_cnt     <= '0;
      Protocol_Err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        beat_cnt <= '0;
      end else if (W_Beat && W_Route_Valid) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (err_ev) Protocol_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aw_w_order_queue.sv
// Randomized bench for aw_w_order_queue against a queue-based reference.
// Directed scenarios first, then random push/beat traffic.
module tb_aw_w_order_queue;

  localparam int DEPTH = 4;

  logic       ACLK = 0;
  logic       ARESET = 1;
  logic       AW_Push = 0;
  logic [0:0] AW_Master_ID = 0;
  logic [0:0] AW_Slave_Sel = 0;
  logic [7:0] AW_Len = 0;
  logic       Queue_Is_Full, Queue_Is_Empty;
  logic [2:0] Queue_Count;
  logic       W_Route_Valid;
  logic [0:0] W_Master_Sel, W_Slave_Sel;
  logic       W_Beat = 0, W_Last_In = 0;
  logic       W_Last_Out, Protocol_Err;

  aw_w_order_queue dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AW_Push(AW_Push), .AW_Master_ID(AW_Master_ID),
    .AW_Slave_Sel(AW_Slave_Sel), .AW_Len(AW_Len),
    .Queue_Is_Full(Queue_Is_Full), .Queue_Is_Empty(Queue_Is_Empty),
    .Queue_Count(Queue_Count), .W_Route_Valid(W_Route_Valid),
    .W_Master_Sel(W_Master_Sel), .W_Slave_Sel(W_Slave_Sel),
    .W_Beat(W_Beat), .W_Last_In(W_Last_In),
    .W_Last_Out(W_Last_Out), .Protocol_Err(Protocol_Err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { int id; int sl; int len; } ent_t;
  ent_t q[$];
  int   bc;
  bit   merr;
  int   errors = 0;
  int   checks = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_last();
    return (q.size() > 0) && (bc == q[0].len);
  endfunction

  task automatic compare();
    bit v;
    v = q.size() > 0;
    check("count", Queue_Count, q.size());
    check("empty", Queue_Is_Empty, q.size() == 0);
    check("full", Queue_Is_Full, q.size() == DEPTH);
    check("valid", W_Route_Valid, v);
    check("msel", W_Master_Sel, v ? q[0].id : 0);
    check("ssel", W_Slave_Sel, v ? q[0].sl : 0);
    check("wlast", W_Last_Out, m_last());
    check("err", Protocol_Err, merr);
  endtask

  task automatic model_step(bit p, int id, int sl, int len, bit b, bit li);
    bit v, l, pop;
    v   = q.size() > 0;
    l   = m_last();
    pop = b && l;
    if (b && !v) merr = 1;
    if (b && v && (li != l)) merr = 1;
    if (p && q.size() == DEPTH && !pop) merr = 1;
    if (pop) begin
      void'(q.pop_front());
      bc = 0;
    end else if (b && v) begin
      bc++;
    end
    if (p && (q.size() < DEPTH || pop)) q.push_back('{id, sl, len});
  endtask

  task automatic cycle(bit p, int id, int sl, int len, bit b, bit li);
    AW_Push = p; AW_Master_ID = id[0]; AW_Slave_Sel = sl[0];
    AW_Len = len[7:0]; W_Beat = b; W_Last_In = li;
    @(posedge ACLK);
    model_step(p, id, sl, len, b, li);
    @(negedge ACLK);
    compare();
  endtask

  task automatic do_reset();
    #2 ARESET = 1;
    q.delete(); bc = 0; merr = 0;
    #1 compare();
    @(negedge ACLK);
    ARESET = 0; AW_Push = 0; W_Beat = 0; W_Last_In = 0;
  endtask

  task automatic beat();
    cycle(0, 0, 0, 0, 1, m_last());
  endtask

  initial begin
    bit p, b, li;
    repeat (2) @(negedge ACLK);
    do_reset();
    // single entry, 4 beats
    cycle(1, 1, 0, 3, 0, 0);
    repeat (4) beat();
    cycle(0, 0, 0, 0, 0, 0);
    // reset mid-burst
    cycle(1, 1, 1, 5, 0, 0);
    beat(); beat();
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    // fill and overflow
    for (int i = 0; i < 4; i++) cycle(1, i & 1, i >> 1, 0, 0, 0);
    cycle(1, 1, 1, 2, 0, 0);
    // push and pop while full
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, i & 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 1);
    repeat (3) beat();
    beat(); beat();
    // back-to-back bursts
    do_reset();
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    repeat (3) beat();
    // WLAST mismatch early, then beat while empty
    do_reset();
    cycle(1, 1, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    beat(); beat();
    do_reset();
    cycle(0, 0, 0, 0, 1, 1);
    // 256-beat burst
    do_reset();
    cycle(1, 1, 1, 255, 0, 0);
    repeat (256) beat();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      p  = $urandom_range(0, 2) == 0;
      b  = (q.size() > 0) ? ($urandom_range(0, 1) == 1)
                          : ($urandom_range(0, 49) == 0);
      li = ($urandom_range(0, 63) == 0) ? ~m_last() : m_last();
      cycle(p, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20)
                                        : $urandom_range(0, 3),
            b, li);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
